// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped data cache controller:
// FSM state encoding, address/data widths and address-split helpers.
package dcache_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WB        = 2'd1,
        S_ALLOC     = 2'd2,
        S_FILL_DONE = 2'd3
    } state_e;

    // Index width: one 16-bit word per line, so the index starts at bit 1.
    function automatic int idx_width(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Tag width: everything above the index.
    function automatic int tag_width(input int num_lines);
        return ADDR_W - 1 - $clog2(num_lines);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] a, input int iw);
        return (a >> 1) & ((16'd1 << iw) - 16'd1);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] a, input int iw);
        return a >> (iw + 1);
    endfunction

    // Rebuild a word address from a (zero-extended) tag and index.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] tag,
                                                    input logic [ADDR_W-1:0] idx,
                                                    input int iw);
        return (tag << (iw + 1)) | (idx << 1);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for the direct-mapped cache.
// One combinational read port, one synchronous write port; valid and dirty
// bits clear asynchronously on reset, tags and data are left as-is.
module dcache_array #(
    parameter int NUM_LINES = 32,
    parameter int IW        = 5,
    parameter int TAG_W     = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IW-1:0]    i_rd_idx,
    output logic             o_rd_valid,
    output logic             o_rd_dirty,
    output logic [TAG_W-1:0] o_rd_tag,
    output logic [15:0]      o_rd_data,
    input  logic             i_we,
    input  logic [IW-1:0]    i_wr_idx,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic [15:0]      i_wr_data,
    input  logic             i_wr_dirty
);

    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [15:0]          r_data [NUM_LINES];

    // Status bits: cleared by reset, every write leaves the line valid.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= 1'b1;
            r_dirty[i_wr_idx] <= i_wr_dirty;
        end
    end

    // Tag and data payload, no reset needed.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    // Combinational read port.
    always_comb begin
        o_rd_valid = r_valid[i_rd_idx];
        o_rd_dirty = r_dirty[i_rd_idx];
        o_rd_tag   = r_tag[i_rd_idx];
        o_rd_data  = r_data[i_rd_idx];
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits complete in the request cycle; misses stall, optionally write back a
// dirty victim, fill the line from backing memory, then complete as a hit.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int IW    = idx_width(NUM_LINES);
    localparam int TAG_W = tag_width(NUM_LINES);

    state_e      r_state;
    state_e      w_state_next;
    logic        r_wr;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;

    logic             w_in_idle;
    logic             w_req_wr;
    logic [15:0]      w_req_addr;
    logic [15:0]      w_req_wdata;
    logic [IW-1:0]    w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic             w_latch;
    logic             w_we;
    logic [15:0]      w_wr_data;
    logic             w_wr_dirty;

    logic             w_rd_valid;
    logic             w_rd_dirty;
    logic [TAG_W-1:0] w_rd_tag;
    logic [15:0]      w_rd_data;

    // Outside IDLE the pipeline inputs are ignored and the latched miss is used.
    always_comb begin
        w_in_idle   = (r_state == S_IDLE);
        w_req_wr    = w_in_idle ? wr    : r_wr;
        w_req_addr  = w_in_idle ? addr  : r_addr;
        w_req_wdata = w_in_idle ? wdata : r_wdata;
        w_idx       = w_req_addr[IW:1];
        w_tag       = w_req_addr[15:IW+1];
        w_hit       = w_rd_valid && (w_rd_tag == w_tag);
    end

    dcache_array #(
        .NUM_LINES (NUM_LINES),
        .IW        (IW),
        .TAG_W     (TAG_W)
    ) u_array (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rd_idx   (w_idx),
        .o_rd_valid (w_rd_valid),
        .o_rd_dirty (w_rd_dirty),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_we       (w_we),
        .i_wr_idx   (w_idx),
        .i_wr_tag   (w_tag),
        .i_wr_data  (w_wr_data),
        .i_wr_dirty (w_wr_dirty)
    );

    // Next state, array write control and all outputs.
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_we         = 1'b0;
        w_wr_data    = w_req_wdata;
        w_wr_dirty   = 1'b1;
        stall        = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        rdata        = 16'h0000;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = 16'h0000;
        mem_wdata    = 16'h0000;

        case (r_state)
            S_IDLE: begin
                if (en) begin
                    if (addr[0]) begin
                        err = 1'b1;
                    end else if (w_hit) begin
                        done = 1'b1;
                        if (w_req_wr) begin
                            w_we = 1'b1;
                        end else begin
                            rdata = w_rd_data;
                        end
                    end else begin
                        stall        = 1'b1;
                        w_latch      = 1'b1;
                        w_state_next = (w_rd_valid && w_rd_dirty) ? S_WB : S_ALLOC;
                    end
                end
            end
            S_WB: begin
                // Array is untouched during WB, so the victim read stays stable.
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = line_addr(16'(w_rd_tag), 16'(w_idx), IW);
                mem_wdata = w_rd_data;
                if (mem_ack) begin
                    w_state_next = S_ALLOC;
                end
            end
            S_ALLOC: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = r_addr;
                if (mem_ack) begin
                    w_we         = 1'b1;
                    w_wr_data    = mem_rdata;
                    w_wr_dirty   = 1'b0;
                    w_state_next = S_FILL_DONE;
                end
            end
            S_FILL_DONE: begin
                done = 1'b1;
                if (r_wr) begin
                    w_we = 1'b1;
                end else begin
                    rdata = w_rd_data;
                end
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // A stray ack is flagged and otherwise has no effect.
        err = err | (mem_ack & ~mem_req);

        if (rst) begin
            w_state_next = S_IDLE;
            w_latch      = 1'b0;
            w_we         = 1'b0;
            stall        = 1'b0;
            done         = 1'b0;
            err          = 1'b0;
            rdata        = 16'h0000;
            mem_req      = 1'b0;
            mem_wr       = 1'b0;
            mem_addr     = 16'h0000;
            mem_wdata    = 16'h0000;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture the missing access so the pipeline inputs can be ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= 1'b0;
            r_addr  <= 16'h0000;
            r_wdata <= 16'h0000;
        end else if (w_latch) begin
            r_wr    <= wr;
            r_addr  <= addr;
            r_wdata <= wdata;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed scenarios plus random traffic
// checked against a flat memory model and a tag/valid/dirty directory.
module tb_dcache_ctrl;

    localparam int NL = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic [15:0] rdata;
    logic        stall;
    logic        done;
    logic        err;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ack = 1'b0;

    dcache_ctrl #(.NUM_LINES(NL)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic        hit;
        logic [15:0] data;
    } resp_t;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } mtxn_t;

    resp_t rq[$];
    mtxn_t mq[$];

    logic [15:0] bmem [256];  // backing memory, changed only through the port
    logic [15:0] arch [256];  // what a load must return
    logic        mv [NL];
    logic        md [NL];
    int          mt [NL];

    int   fix_lat = 0;
    logic auto_mem = 1'b1;
    int   stray_req = 0;
    int   stray_done = 0;
    logic quiet = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < NL; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
            mt[i] = 0;
        end
        for (int i = 0; i < 256; i++) arch[i] = bmem[i];
    endtask

    // Backing memory responder; also produces requested stray ack pulses.
    initial begin
        int lat_cnt;
        lat_cnt = 0;
        for (int i = 0; i < 256; i++) bmem[i] = 16'($urandom);
        bmem[32] = 16'hBEEF;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack   = 1'b0;
                mem_rdata = 16'h0000;
            end else if (stray_req != stray_done) begin
                mem_ack = 1'b1;
                stray_done++;
            end else if (auto_mem && mem_req) begin
                if (lat_cnt <= 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = bmem[mem_addr[8:1]];
                    if (mem_wr) bmem[mem_addr[8:1]] = mem_wdata;
                    lat_cnt = (fix_lat > 0) ? fix_lat - 1 : int'($urandom_range(0, 3));
                end else begin
                    lat_cnt--;
                end
            end else if (!mem_req) begin
                lat_cnt = (fix_lat > 0) ? fix_lat - 1 : int'($urandom_range(0, 3));
            end
        end
    end

    // Monitor: pops expectations whenever the DUT completes an access or a
    // memory transfer is acknowledged.
    initial begin
        int    stall_run;
        resp_t r;
        mtxn_t m;
        stall_run = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (mem_req && mem_ack) begin
                    if (mq.size() == 0) begin
                        check("mem_unexpected_txn", 64'(mem_addr), 64'hFFFF_FFFF);
                    end else begin
                        m = mq.pop_front();
                        check("mem_wr", 64'(mem_wr), 64'(m.wr));
                        check("mem_addr", 64'(mem_addr), 64'(m.addr));
                        if (m.wr) check("mem_wdata", 64'(mem_wdata), 64'(m.data));
                    end
                end
                if (mem_req && !mem_wr) check("mem_wdata_zero", 64'(mem_wdata), 64'h0);
                if (quiet) check("err_quiet", 64'(err), 64'h0);
                if (done) begin
                    if (rq.size() == 0) begin
                        check("done_unexpected", 64'(addr), 64'hFFFF_FFFF);
                    end else begin
                        r = rq.pop_front();
                        check("hit_no_stall", 64'(stall_run == 0), 64'(r.hit));
                        if (!r.wr) check("rdata", 64'(rdata), 64'(r.data));
                    end
                    stall_run = 0;
                end else if (stall) begin
                    stall_run++;
                end else begin
                    stall_run = 0;
                end
            end
        end
    end

    // Issue one access: predict its outcome, then drive it until done.
    task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                          output int stalls, output logic [15:0] rd);
        int    idx;
        int    tag;
        logic  hit;
        resp_t r;
        mtxn_t m;
        idx = (int'(a) >> 1) % NL;
        tag = int'(a) / (2 * NL);
        hit = mv[idx] && (mt[idx] == tag);
        if (!hit) begin
            if (mv[idx] && md[idx]) begin
                m.wr   = 1'b1;
                m.addr = 16'(mt[idx] * 2 * NL + idx * 2);
                m.data = arch[m.addr[8:1]];
                mq.push_back(m);
            end
            m.wr   = 1'b0;
            m.addr = a;
            m.data = 16'h0000;
            mq.push_back(m);
        end
        r.wr   = w;
        r.hit  = hit;
        r.data = arch[a[8:1]];
        rq.push_back(r);
        if (w) arch[a[8:1]] = d;
        md[idx] = w | (hit & md[idx]);
        mv[idx] = 1'b1;
        mt[idx] = tag;

        @(negedge clk);
        en    = 1'b1;
        wr    = w;
        addr  = a;
        wdata = d;
        #2;
        check("idle_mem_req", 64'(mem_req), 64'h0);
        stalls = 0;
        while (!done && stalls < 40) begin
            @(negedge clk);
            #2;
            stalls++;
        end
        rd = rdata;
        if (!done) check("access_timeout", 64'(stalls), 64'h0);
        @(posedge clk);
        #1;
        en = 1'b0;
        wr = 1'b0;
    endtask

    initial begin
        int          st;
        logic [15:0] rd;

        // Reset: every output held low even with requests and a stray ack.
        rst  = 1'b1;
        en   = 1'b1;
        wr   = 1'b1;
        addr = 16'h0041;
        repeat (2) @(negedge clk);
        @(posedge clk);
        stray_req++;
        @(negedge clk);
        #2;
        check("reset_outputs",
              {11'h0, stall, done, err, mem_req, mem_wr, mem_addr, mem_wdata, rdata}, 64'h0);
        en   = 1'b0;
        wr   = 1'b0;
        addr = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        @(negedge clk);
        #2;
        check("idle_outputs", {12'h0, stall, done, err, mem_req, rdata}, 64'h0);
        quiet = 1'b1;

        // Cold load, ack latency 3.
        fix_lat = 3;
        access(1'b0, 16'h0040, 16'h0000, st, rd);
        check("cold_stall_cycles", 64'(st), 64'd4);
        check("cold_rdata", 64'(rd), 64'hBEEF);

        // Store then load hit in the same cycle.
        access(1'b1, 16'h0040, 16'h1234, st, rd);
        check("store_hit_stalls", 64'(st), 64'd0);
        access(1'b0, 16'h0040, 16'h0000, st, rd);
        check("load_hit_stalls", 64'(st), 64'd0);
        check("load_hit_rdata", 64'(rd), 64'h1234);

        // Conflict miss with dirty victim: write-back then fill.
        fix_lat = 0;
        access(1'b0, 16'h0080, 16'h0000, st, rd);
        check("wb_memory_value", 64'(bmem[32]), 64'h1234);

        // Misaligned access is flagged and has no effect.
        quiet = 1'b0;
        @(negedge clk);
        en    = 1'b1;
        wr    = 1'b1;
        addr  = 16'h0041;
        wdata = 16'hDEAD;
        #2;
        check("misalign_err", {stall, done, err, mem_req}, 64'b0010);
        @(posedge clk);
        #1;
        en = 1'b0;
        wr = 1'b0;
        @(negedge clk);
        #2;
        check("misalign_err_clears", 64'(err), 64'h0);
        quiet = 1'b1;
        access(1'b0, 16'h0080, 16'h0000, st, rd);
        check("misalign_line_intact", 64'(st), 64'd0);

        // Random traffic over four tags per index.
        for (int i = 0; i < 300; i++) begin
            access(1'($urandom_range(0, 1)), 16'($urandom_range(0, 127) << 1),
                   16'($urandom), st, rd);
        end
        repeat (3) @(negedge clk);
        check("resp_queue_drained", 64'(rq.size()), 64'h0);
        check("mem_queue_drained", 64'(mq.size()), 64'h0);

        // Reset during ALLOC, then a late ack.
        quiet    = 1'b0;
        auto_mem = 1'b0;
        @(negedge clk);
        en   = 1'b1;
        wr   = 1'b0;
        addr = 16'h0100;
        #2;
        if (mq.size() == 0) check("alloc_miss_stall", 64'(stall), 64'h1);
        @(negedge clk);
        #2;
        check("alloc_mem_req", {mem_req, mem_wr}, 64'b10);
        #1;
        rst = 1'b1;
        #1;
        check("rst_drops_req", {stall, mem_req}, 64'b00);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        reset_model();
        @(posedge clk);
        stray_req++;
        @(negedge clk);
        #2;
        check("late_ack_err", {err, mem_req, done}, 64'b100);
        auto_mem = 1'b1;
        @(negedge clk);
        quiet = 1'b1;
        access(1'b0, 16'h0040, 16'h0000, st, rd);
        check("post_reset_miss", 64'(st > 0), 64'h1);

        repeat (3) @(negedge clk);
        check("final_queues_empty", 64'(rq.size() + mq.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d",
                 checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter NUM_LINES, default 32, number of direct-mapped one-word lines (power of two, 2..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port en  input  1  access request from memory stage.
REQ-005 SHALL have port wr  input  1  1 = store, 0 = load; valid when en=1.
REQ-006 SHALL have port addr  input  16  byte address; bit 0 must be 0.
REQ-007 SHALL have port wdata  input  16  store data.
REQ-008 SHALL have port rdata  output  16  load data, valid when done=1 and wr=0.
REQ-009 SHALL have port stall  output  1  pipeline must hold memory-stage inputs stable.
REQ-010 SHALL have port done  output  1  one-cycle access-complete strobe.
REQ-011 SHALL have port err  output  1  illegal-condition flag.
REQ-012 SHALL have ports mem_req/mem_wr (output 1), mem_addr/mem_wdata (output 16), mem_rdata (input 16), mem_ack (input 1) for the backing memory.

Function
REQ-013 SHALL split addr as: index = addr[IW:1] (IW = log2(NUM_LINES)), tag = addr[15:IW+1].
REQ-014 SHALL implement FSM states IDLE, WB, ALLOC, FILL_DONE; outputs decoded from state plus hit logic.
REQ-015 IDLE, en=1, hit (valid and tag match): SHALL assert done=1 and stall=0 in the same cycle; load drives rdata = line data combinationally; store writes wdata and sets dirty at the clock edge.
REQ-016 IDLE, en=1, miss: SHALL assert stall=1 in the same cycle, latch wr/addr/wdata, and go to WB if victim is valid and dirty, else to ALLOC.
REQ-017 WB: SHALL drive mem_req=1, mem_wr=1, mem_addr={victim tag, index, 1'b0}, mem_wdata=victim data, stable until mem_ack; on mem_ack go to ALLOC.
REQ-018 ALLOC: SHALL drive mem_req=1, mem_wr=0, mem_addr=latched addr; on mem_ack write mem_rdata into the line, set tag, valid=1, dirty=0, and go to FILL_DONE.
REQ-019 FILL_DONE: SHALL complete the latched access as a hit (done=1, stall=0, store merges wdata and sets dirty) and return to IDLE.
REQ-020 stall SHALL be 1 continuously from the miss-detect cycle through the ALLOC ack cycle; a clean miss with ack latency L completes in L+2 cycles.
REQ-021 In WB/ALLOC/FILL_DONE, en/addr/wr/wdata SHALL be ignored; the latched copies are used.
REQ-022 mem_req SHALL be 0 in IDLE and FILL_DONE; mem_wdata SHALL be 0 when mem_wr=0.
REQ-023 en=1 with addr[0]=1 SHALL assert err that cycle, with no state change, no array update, and no memory request.
REQ-024 mem_ack=1 while mem_req=0 SHALL assert err that cycle and be otherwise ignored.
REQ-025 en=0 in IDLE SHALL produce done=0, stall=0, rdata=0.

Reset
REQ-026 rst SHALL immediately force state IDLE and clear all valid and dirty bits; data and tag contents need not be cleared.
REQ-027 During reset, stall, done, err, mem_req, mem_wr, mem_addr, mem_wdata, and rdata SHALL all be 0.
REQ-028 Reset asserted mid-WB or mid-ALLOC SHALL abort the miss, drop mem_req asynchronously, and discard any later mem_ack (err asserted as in REQ-024).

Structure
REQ-029 State enum, IW/TAG_W width constants, and the address-split helpers SHALL live in the shared package dcache_pkg.
REQ-030 Tag/valid/dirty/data storage SHALL be one sub-module, dcache_array (one combinational read port, one write port, async clear of valid/dirty).

Verification
REQ-031 Cold load 0x0040, mem_ack after 3 cycles returning 0xBEEF: stall high for 4 cycles, then done=1, rdata=0xBEEF, and mem_req seen only in ALLOC.
REQ-032 Store 0x1234 to 0x0040 after fill, then load 0x0040: both complete the same cycle (stall=0), and rdata=0x1234.
REQ-033 Dirty 0x0040 (NUM_LINES=32), then load 0x0080 (same index): WB writes 0x1234 to mem_addr 0x0040, then ALLOC reads 0x0080, then done.
REQ-034 en=1 with addr=0x0041: err=1 for one cycle, stall=0, mem_req=0, and the line is unchanged.
REQ-035 rst pulse during ALLOC, then mem_ack: mem_req=0 immediately, err=1 on the ack, and a following load 0x0040 misses.
